// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 target that emulates the read path of a serial NOR flash.
// The SPI pins are oversampled on clk_i, and data bytes come from a byte-wide read port.
module spi_flash_responder #(
   parameter logic [23:0] JedecId   = 24'hEF4018,
   parameter int unsigned AddrWidth = 24
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 spi_sck_i,
   input  logic                 spi_csb_i,
   input  logic                 spi_mosi_i,
   output logic                 spi_miso_o,
   output logic                 spi_miso_oe_o,
   output logic                 mem_req_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   input  logic                 mem_rvalid_i,
   input  logic [7:0]           mem_rdata_i,
   output logic                 underrun_o
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_RDATA, ST_RID, ST_RSR, ST_IGNORE
   } state_e;

   localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);

   state_e               state;
   logic [1:0]           sck_sync, csb_sync, mosi_sync;
   logic                 sck_prev, csb_prev;
   logic                 sck_s, csb_s, mosi_s;
   logic                 sck_rise, sck_fall, cs_fall;
   logic [4:0]           bit_cnt;
   logic [2:0]           tx_cnt;
   logic [1:0]           id_idx;
   logic [6:0]           cmd_sr;
   logic [22:0]          addr_sr;
   logic [7:0]           tx_sr, rd_buf;
   logic [AddrWidth-1:0] addr;
   logic                 buf_valid, outstanding, discard, need_req;
   logic [7:0]           cmd_next;
   logic [23:0]          addr_next;
   logic [7:0]           load_byte;
   logic                 load_hit;
   logic                 rvalid_live;

   assign sck_s       = sck_sync[1];
   assign csb_s       = csb_sync[1];
   assign mosi_s      = mosi_sync[1];
   assign sck_rise    = sck_s & ~sck_prev;
   assign sck_fall    = ~sck_s & sck_prev;
   assign cs_fall     = csb_prev & ~csb_s;
   assign cmd_next    = {cmd_sr, mosi_s};
   assign addr_next   = {addr_sr, mosi_s};
   assign rvalid_live = mem_rvalid_i & outstanding & ~discard;

   // Byte to present at the start of a response byte; data arriving on the load
   // cycle itself is forwarded rather than counted as an underrun.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      load_byte = 8'h00;
      load_hit  = 1'b1;
      case (state)
         ST_RDATA: begin
            if (buf_valid) begin
               load_byte = rd_buf;
            end else if (rvalid_live) begin
               load_byte = mem_rdata_i;
            end else begin
               load_byte = 8'hFF;
               load_hit  = 1'b0;
            end
         end
         ST_RID: begin
            case (id_idx)
               2'd0:    load_byte = JedecId[23:16];
               2'd1:    load_byte = JedecId[15:8];
               2'd2:    load_byte = JedecId[7:0];
               default: load_byte = 8'h00;
            endcase
         end
         default: load_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state         <= ST_IDLE;
         sck_sync      <= 2'b00;
         csb_sync      <= 2'b11;
         mosi_sync     <= 2'b00;
         sck_prev      <= 1'b0;
         csb_prev      <= 1'b1;
         bit_cnt       <= '0;
         tx_cnt        <= '0;
         id_idx        <= '0;
         cmd_sr        <= '0;
         addr_sr       <= '0;
         tx_sr         <= '0;
         rd_buf        <= '0;
         addr          <= '0;
         buf_valid     <= 1'b0;
         outstanding   <= 1'b0;
         discard       <= 1'b0;
         need_req      <= 1'b0;
         spi_miso_o    <= 1'b0;
         spi_miso_oe_o <= 1'b0;
         mem_req_o     <= 1'b0;
         mem_addr_o    <= '0;
         underrun_o    <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; where two statements below assign the same
         // register in one cycle, the later one deliberately takes priority.
         sck_sync   <= {sck_sync[0], spi_sck_i};
         csb_sync   <= {csb_sync[0], spi_csb_i};
         mosi_sync  <= {mosi_sync[0], spi_mosi_i};
         sck_prev   <= sck_s;
         csb_prev   <= csb_s;
         mem_req_o  <= 1'b0;
         underrun_o <= 1'b0;

         if (mem_rvalid_i && outstanding) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
            if (!discard) begin
               rd_buf    <= mem_rdata_i;
               buf_valid <= 1'b1;
            end
         end

         // Prefetch held back while a stale request was still in flight.
         if (state == ST_RDATA && !csb_s && need_req && !outstanding) begin
            mem_req_o   <= 1'b1;
            mem_addr_o  <= addr;
            outstanding <= 1'b1;
            need_req    <= 1'b0;
         end

         if (csb_s) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            tx_cnt        <= '0;
            id_idx        <= '0;
            tx_sr         <= '0;
            buf_valid     <= 1'b0;
            need_req      <= 1'b0;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            if (outstanding && !mem_rvalid_i) discard <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cs_fall) begin
                     state   <= ST_CMD;
                     bit_cnt <= '0;
                  end
               end
               ST_CMD: begin
                  if (sck_rise) begin
                     cmd_sr  <= cmd_next[6:0];
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        case (cmd_next)
                           8'h03:   state <= ST_ADDR;
                           8'h9F:   state <= ST_RID;
                           8'h05:   state <= ST_RSR;
                           default: state <= ST_IGNORE;
                        endcase
                     end
                  end
               end
               ST_ADDR: begin
                  if (sck_rise) begin
                     addr_sr <= addr_next[22:0];
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd23) begin
                        bit_cnt     <= '0;
                        state       <= ST_RDATA;
                        addr        <= addr_next[AddrWidth-1:0];
                        mem_addr_o  <= addr_next[AddrWidth-1:0];
                        mem_req_o   <= 1'b1;
                        outstanding <= 1'b1;
                        buf_valid   <= 1'b0;
                     end
                  end
               end
               ST_RDATA, ST_RID, ST_RSR: begin
                  if (sck_fall) begin
                     spi_miso_oe_o <= 1'b1;
                     tx_cnt        <= tx_cnt + 3'd1;
                     if (tx_cnt == 3'd0) begin
                        spi_miso_o <= load_byte[7];
                        tx_sr      <= {load_byte[6:0], 1'b0};
                        if (state == ST_RID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                        if (state == ST_RDATA) begin
                           buf_valid <= 1'b0;
                           addr      <= addr + AddrOne;
                           if (!load_hit) begin
                              underrun_o <= 1'b1;
                              if (outstanding && !mem_rvalid_i) discard <= 1'b1;
                           end
                           if (outstanding && !mem_rvalid_i) begin
                              need_req <= 1'b1;
                           end else begin
                              mem_req_o   <= 1'b1;
                              mem_addr_o  <= addr + AddrOne;
                              outstanding <= 1'b1;
                           end
                        end
                     end else begin
                        spi_miso_o <= tx_sr[7];
                        tx_sr      <= {tx_sr[6:0], 1'b0};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
